// File: rtl/ula_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode constants,
// fixed widths, FSM state encoding and a one-hot helper for requester ids.
package ula_pkg;

   localparam int DADO_W = 8;
   localparam int OP_W   = 3;
   localparam int N_REQ  = 2;

   localparam logic [OP_W-1:0] ULA_AND = 3'b000;
   localparam logic [OP_W-1:0] ULA_OR  = 3'b001;
   localparam logic [OP_W-1:0] ULA_ADD = 3'b010;
   localparam logic [OP_W-1:0] ULA_SUB = 3'b011;
   localparam logic [OP_W-1:0] ULA_SLT = 3'b100;
   localparam logic [OP_W-1:0] ULA_NOR = 3'b101;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      RESPONDE = 2'd2
   } estado_t;

   // Requester id (0/1) to its bit in the req_pronto / resp_valido vectors.
   function automatic logic [N_REQ-1:0] um_quente(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/arbitro_ula_alu.sv
// Purely combinational 8-bit ALU shared by both requesters.
// Unused opcodes (110/111) produce zero; ADD/SUB wrap modulo 256.
module arbitro_ula_alu
   import ula_pkg::*;
(
   input  logic [DADO_W-1:0] entrada1,
   input  logic [DADO_W-1:0] entrada2,
   input  logic [OP_W-1:0]   sinal_ula,
   output logic [DADO_W-1:0] saida_ula
);

   // Select the operation; SLT is an unsigned compare returning 1 or 0.
   always_comb begin
      saida_ula = '0;
      case (sinal_ula)
         ULA_AND: saida_ula = entrada1 & entrada2;
         ULA_OR:  saida_ula = entrada1 | entrada2;
         ULA_ADD: saida_ula = entrada1 + entrada2;
         ULA_SUB: saida_ula = entrada1 - entrada2;
         ULA_SLT: saida_ula = (entrada1 < entrada2) ? 8'd1 : 8'd0;
         ULA_NOR: saida_ula = ~(entrada1 | entrada2);
         default: saida_ula = '0;
      endcase
   end

endmodule

// File: rtl/arbitro_ula.sv
// Round-robin arbiter in front of a single ALU. One transaction in flight:
// grant in OCIOSO, compute in EXECUTA, hold the response in RESPONDE until
// the owning requester accepts it.
module arbitro_ula
   import ula_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req_valido,
   output logic [N_REQ-1:0]  req_pronto,
   input  logic [DADO_W-1:0] req0_entrada1,
   input  logic [DADO_W-1:0] req0_entrada2,
   input  logic [OP_W-1:0]   req0_sinal_ula,
   input  logic [DADO_W-1:0] req1_entrada1,
   input  logic [DADO_W-1:0] req1_entrada2,
   input  logic [OP_W-1:0]   req1_sinal_ula,
   output logic [N_REQ-1:0]  resp_valido,
   input  logic [N_REQ-1:0]  resp_aceito,
   output logic [DADO_W-1:0] resultado,
   output logic              zero,
   output logic              ocupado
);

   estado_t           estado;
   logic              ultimo;
   logic              concede;

   logic [DADO_W-1:0] entrada1_p0;
   logic [DADO_W-1:0] entrada2_p0;
   logic [OP_W-1:0]   sinal_ula_p0;
   logic              id_p0;

   logic [DADO_W-1:0] saida_ula;

   // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
   always_comb begin
      concede = 1'b0;
      case (req_valido)
         2'b01:   concede = 1'b0;
         2'b10:   concede = 1'b1;
         2'b11:   concede = ~ultimo;
         default: concede = 1'b0;
      endcase
      req_pronto = '0;
      if (!reset && (estado == OCIOSO) && (|req_valido))
         req_pronto = um_quente(concede);
   end

   // Grant cycle: latch the winner's operands, opcode and id (data, not reset).
   always_ff @(posedge clock) begin
      if (|req_pronto) begin
         entrada1_p0  <= concede ? req1_entrada1  : req0_entrada1;
         entrada2_p0  <= concede ? req1_entrada2  : req0_entrada2;
         sinal_ula_p0 <= concede ? req1_sinal_ula : req0_sinal_ula;
         id_p0        <= concede;
      end
   end

   arbitro_ula_alu u_alu (
      .entrada1  (entrada1_p0),
      .entrada2  (entrada2_p0),
      .sinal_ula (sinal_ula_p0),
      .saida_ula (saida_ula)
   );

   // Sequencing FSM with registered result, flag and response-valid outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado      <= OCIOSO;
         ultimo      <= 1'b1;
         resultado   <= '0;
         zero        <= 1'b0;
         resp_valido <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (|req_valido)
                  estado <= EXECUTA;
            end
            // ---- stage boundary: captured operands -> registered result ----
            EXECUTA: begin
               resultado   <= saida_ula;
               zero        <= (saida_ula == '0);
               resp_valido <= um_quente(id_p0);
               estado      <= RESPONDE;
            end
            // ---- stage boundary: response held until its owner accepts ----
            RESPONDE: begin
               if (resp_aceito[id_p0]) begin
                  resp_valido <= '0;
                  ultimo      <= id_p0;
                  estado      <= OCIOSO;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign ocupado = (estado != OCIOSO);

endmodule

// File: doc/arbitro_ula.md
ARBITRO_ULA -- requirements
Module: arbitro_ula

Interface
REQ-001 Parameters: none; all widths fixed (8-bit data, 3-bit opcode, 2 requesters).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valido  input  2  bit i: requester i presents an operation.
REQ-005 req_pronto  output  2  bit i: operation of requester i accepted this cycle.
REQ-006 req0_entrada1 / req0_entrada2  input  8 each  requester 0 operands.
REQ-007 req0_sinal_ula  input  3  requester 0 opcode.
REQ-008 req1_entrada1 / req1_entrada2  input  8 each  requester 1 operands.
REQ-009 req1_sinal_ula  input  3  requester 1 opcode.
REQ-010 resp_valido  output  2  bit i: resultado belongs to requester i and is valid.
REQ-011 resp_aceito  input  2  bit i: requester i consumes the response.
REQ-012 resultado  output  8  registered ALU result.
REQ-013 zero  output  1  registered flag, resultado == 0.
REQ-014 ocupado  output  1  high whenever state is not OCIOSO.

Function
REQ-015 FSM states OCIOSO, EXECUTA, RESPONDE; exactly one transaction in flight.
REQ-016 OCIOSO, no req_valido: stay; req_pronto = 00.
REQ-017 OCIOSO, one req_valido bit set: grant that requester.
REQ-018 OCIOSO, both set: grant requester != ultimo (round-robin).
REQ-019 Grant: req_pronto[g] = 1 combinationally that cycle, other bit 0; capture operands, opcode, id g; next state EXECUTA.
REQ-020 req_pronto = 00 in EXECUTA and RESPONDE.
REQ-021 EXECUTA: captured operands drive ALU; register resultado and zero; next state RESPONDE.
REQ-022 Latency: handshake in cycle T; resp_valido[g] = 1 from cycle T+2.
REQ-023 RESPONDE: resp_valido[g] = 1, other bit 0; resultado/zero held stable until resp_aceito[g] = 1.
REQ-024 RESPONDE with resp_aceito[g] = 1: ultimo <= g; next state OCIOSO; no new grant in that same cycle; resp_aceito[!g] ignored.
REQ-025 Minimum throughput: one operation per 3 cycles.
REQ-026 Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (unsigned, result 1/0), 101 NOR, 110/111 result 0.
REQ-027 ADD/SUB wrap modulo 256; no carry/overflow output.
REQ-028 Requester deasserting req_valido before handshake: legal, no state change.
REQ-029 Operand inputs not sampled outside the grant cycle.

Reset
REQ-030 Reset (synchronous, active-high) forces: state OCIOSO, ultimo = 1 (requester 0 wins first tie), resultado = 0x00, zero = 0, resp_valido = 00, ocupado = 0.
REQ-031 req_pronto = 00 in any cycle reset is high.
REQ-032 Reset in EXECUTA or RESPONDE discards the transaction; no response ever issued for it.

Structure
REQ-033 Shared package ula_pkg: opcode constants (ULA_AND..ULA_NOR), FSM state typedef/encoding.
REQ-034 One sub-module: ALU, instantiated once, result taken from its saida_ula port; all sequencing lives in arbitro_ula.

Verification
REQ-035 Req0 ADD 0xF0,0x20 at T -> req_pronto=01 at T; resultado=0x10, zero=0, resp_valido=01 at T+2.
REQ-036 After reset, both valid same cycle: req0 SUB 0x05,0x05; req1 SLT 0x03,0x07 -> req0 first (0x00, zero=1); req1 next (0x01, zero=0).
REQ-037 Both held valid, resp_aceito tied 11, 6 transactions -> grant order 0,1,0,1,0,1.
REQ-038 resp_aceito held 00 for 5 cycles in RESPONDE -> resultado/resp_valido stable, req_pronto=00, ocupado=1.
REQ-039 Reset asserted in EXECUTA -> next cycle resp_valido=00, resultado=0x00, ocupado=0; no response later.
REQ-040 Opcode 111 with 0xFF,0xFF -> 0x00, zero=1; NOR 0x0F,0xF0 -> 0x00, zero=1; SLT 0x80,0x7F -> 0x00.
